// File: rtl/cdp1802_pkg.sv
// Shared definitions for the cdp1802 machine-cycle controller.
//   SC_*          : two-bit state codes driven on SC (S0..S3)
//   cycle_state_e : arbiter cycle states
//   req_t         : request snapshot latched at TPB
//   DEF_*         : default cycle length and pulse phases
package cdp1802_pkg;

  localparam logic [1:0] SC_FETCH = 2'b00;
  localparam logic [1:0] SC_EXEC  = 2'b01;
  localparam logic [1:0] SC_DMA   = 2'b10;
  localparam logic [1:0] SC_INT   = 2'b11;

  localparam int unsigned DEF_CYCLE_LEN = 8;
  localparam int unsigned DEF_TPA_PHASE = 1;
  localparam int unsigned DEF_TPB_PHASE = 6;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DMA   = 3'd3,
    ST_INTR  = 3'd4
  } cycle_state_e;

  typedef struct packed {
    logic dma_in;
    logic dma_out;
    logic intr;
  } req_t;

  // State code presented on SC for a given cycle state; INIT reports as S1.
  function automatic logic [1:0] state_sc(cycle_state_e s);
    logic [1:0] sc;
    sc = SC_FETCH;
    case (s)
      ST_INIT:  sc = SC_EXEC;
      ST_FETCH: sc = SC_FETCH;
      ST_EXEC:  sc = SC_EXEC;
      ST_DMA:   sc = SC_DMA;
      ST_INTR:  sc = SC_INT;
      default:  sc = SC_FETCH;
    endcase
    return sc;
  endfunction

endpackage

// File: rtl/cdp1802_phase_ctr.sv
// Phase counter for one machine cycle with WAIT_N pause gating.
// Each clock is either running (WAIT_N high at the edge that starts it) or
// paused; the phase advances only at the end of a running clock, and the
// timing pulses fire only during a running clock at their phase.
//   CLOCK, CLEAR_N : clock, asynchronous active-low reset
//   WAIT_N         : synchronous pause, active-low
//   phase          : current phase within the cycle
//   TPA, TPB       : one-clock timing pulses at TPA_PHASE / TPB_PHASE
//   commit         : one-clock strobe at the last phase
module cdp1802_phase_ctr
  import cdp1802_pkg::*;
#(
  parameter int unsigned CYCLE_LEN = DEF_CYCLE_LEN,
  parameter int unsigned TPA_PHASE = DEF_TPA_PHASE,
  parameter int unsigned TPB_PHASE = DEF_TPB_PHASE
) (
  input  logic                         CLOCK,
  input  logic                         CLEAR_N,
  input  logic                         WAIT_N,
  output logic [$clog2(CYCLE_LEN)-1:0] phase,
  output logic                         TPA,
  output logic                         TPB,
  output logic                         commit
);

  localparam int unsigned PW = $clog2(CYCLE_LEN);
  localparam logic [PW-1:0] LAST_P = PW'(CYCLE_LEN - 1);
  localparam logic [PW-1:0] TPA_P  = PW'(TPA_PHASE);
  localparam logic [PW-1:0] TPB_P  = PW'(TPB_PHASE);

  // run_q: the clock now in progress is a running (not paused) clock.
  logic          run_q;
  logic [PW-1:0] phase_nxt_c;

  // Power-of-two length lets the counter wrap naturally.
  assign phase_nxt_c = run_q ? phase + PW'(1) : phase;

  always_ff @(posedge CLOCK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      phase  <= '0;
      run_q  <= 1'b1;
      TPA    <= 1'b0;
      TPB    <= 1'b0;
      commit <= 1'b0;
    end else begin
      phase  <= phase_nxt_c;
      run_q  <= WAIT_N;
      TPA    <= WAIT_N && (phase_nxt_c == TPA_P);
      TPB    <= WAIT_N && (phase_nxt_c == TPB_P);
      commit <= WAIT_N && (phase_nxt_c == LAST_P);
    end
  end

endmodule

// File: rtl/cdp1802_cycle_ctrl.sv
// Machine-cycle sequencer and S2/S3 arbiter for the cdp1802 core.
// Splits CLOCK into CYCLE_LEN-clock machine cycles, drives TPA/TPB/SC and
// picks the next cycle (fetch, execute, DMA, interrupt) at each boundary.
// Build option: define CDP1802_DMA_EN to enable DMA arbitration; without it
// the DMA requests are ignored and the DMA grants stay 0.
//   CLOCK, CLEAR_N           : clock, asynchronous active-low reset
//   WAIT_N                   : synchronous pause, active-low
//   INT_N, IE                : interrupt request (active-low) and enable
//   dma_in_req, dma_out_req  : DMA requests, active-high
//   idle, exec_more          : core status used for the next-cycle decision
//   SC, phase                : state code and phase within the cycle
//   TPA, TPB, commit         : timing pulses and end-of-cycle strobe
//   dma_in_gnt, dma_out_gnt  : S2 grants; int_gnt : S3 grant
//   init                     : post-reset initialisation cycle
module cdp1802_cycle_ctrl
  import cdp1802_pkg::*;
#(
  parameter int unsigned CYCLE_LEN = DEF_CYCLE_LEN,
  parameter int unsigned TPA_PHASE = DEF_TPA_PHASE,
  parameter int unsigned TPB_PHASE = DEF_TPB_PHASE
) (
  input  logic                         CLOCK,
  input  logic                         CLEAR_N,
  input  logic                         WAIT_N,
  input  logic                         INT_N,
  input  logic                         IE,
  input  logic                         dma_in_req,
  input  logic                         dma_out_req,
  input  logic                         idle,
  input  logic                         exec_more,
  output logic [1:0]                   SC,
  output logic                         TPA,
  output logic                         TPB,
  output logic [$clog2(CYCLE_LEN)-1:0] phase,
  output logic                         commit,
  output logic                         dma_in_gnt,
  output logic                         dma_out_gnt,
  output logic                         int_gnt,
  output logic                         init
);

  cycle_state_e state;
  cycle_state_e nxt_c;
  logic         nxt_din_c;
  logic         nxt_dout_c;
  req_t         req_q;
  req_t         req_c;
  logic         sample_c;

  cdp1802_phase_ctr #(
    .CYCLE_LEN (CYCLE_LEN),
    .TPA_PHASE (TPA_PHASE),
    .TPB_PHASE (TPB_PHASE)
  ) u_phase_ctr (
    .CLOCK   (CLOCK),
    .CLEAR_N (CLEAR_N),
    .WAIT_N  (WAIT_N),
    .phase   (phase),
    .TPA     (TPA),
    .TPB     (TPB),
    .commit  (commit)
  );

  // Live request snapshot; DMA inputs only participate when DMA is built in.
`ifdef CDP1802_DMA_EN
  assign req_c.dma_in  = dma_in_req;
  assign req_c.dma_out = dma_out_req;
`else
  logic dma_unused;
  assign dma_unused    = dma_in_req ^ dma_out_req;
  assign req_c.dma_in  = 1'b0;
  assign req_c.dma_out = 1'b0;
`endif
  assign req_c.intr = !INT_N && IE;

  // Fetch and init cycles never sample requests. TPB is high only during a
  // running clock, so the latch freezes automatically while paused.
  assign sample_c = TPB && ((state == ST_EXEC) || (state == ST_DMA) || (state == ST_INTR));

  // Next-cycle decision, applied on the edge that ends the commit clock.
  always_comb begin
    nxt_c      = ST_FETCH;
    nxt_din_c  = 1'b0;
    nxt_dout_c = 1'b0;
    case (state)
      ST_INIT:  nxt_c = ST_FETCH;
      ST_FETCH: nxt_c = ST_EXEC;
      ST_EXEC, ST_DMA: begin
        if ((state == ST_EXEC) && exec_more) begin
          nxt_c = ST_EXEC;
        end else if (req_q.dma_in) begin
          nxt_c     = ST_DMA;
          nxt_din_c = 1'b1;
        end else if (req_q.dma_out) begin
          nxt_c      = ST_DMA;
          nxt_dout_c = 1'b1;
        end else if (req_q.intr) begin
          nxt_c = ST_INTR;
        end else begin
          nxt_c = idle ? ST_EXEC : ST_FETCH;
        end
      end
      // IE is cleared by the core in S3, so interrupts never chain.
      ST_INTR: begin
        if (req_q.dma_in) begin
          nxt_c     = ST_DMA;
          nxt_din_c = 1'b1;
        end else if (req_q.dma_out) begin
          nxt_c      = ST_DMA;
          nxt_dout_c = 1'b1;
        end else begin
          nxt_c = ST_FETCH;
        end
      end
      default: nxt_c = ST_FETCH;
    endcase
  end

  // Cycle state and its registered decodes; latched requests clear every
  // boundary so each cycle decides only on what it sampled itself.
  always_ff @(posedge CLOCK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      state       <= ST_INIT;
      SC          <= SC_EXEC;
      init        <= 1'b1;
      dma_in_gnt  <= 1'b0;
      dma_out_gnt <= 1'b0;
      int_gnt     <= 1'b0;
      req_q       <= '0;
    end else if (commit) begin
      state       <= nxt_c;
      SC          <= state_sc(nxt_c);
      init        <= (nxt_c == ST_INIT);
      dma_in_gnt  <= nxt_din_c;
      dma_out_gnt <= nxt_dout_c;
      int_gnt     <= (nxt_c == ST_INTR);
      req_q       <= '0;
    end else if (sample_c) begin
      req_q <= req_c;
    end
  end

endmodule

// File: doc/cdp1802_cycle_ctrl.md
# cdp1802_cycle_ctrl

Machine-cycle sequencer and S2/S3 arbiter for the `cdp1802` core. It divides `CLOCK` into 8-clock machine cycles and drives `TPA`/`TPB` and the state code `SC`. At each cycle boundary it chooses the next cycle type: fetch, execute, DMA or interrupt. It issues one commit strobe per cycle so the core advances exactly one machine cycle per 8 clocks.

## Interface

- `CYCLE_LEN`, 8: clocks per machine cycle; minimum 8, must be a power of two.
- `TPA_PHASE`, 1: phase at which `TPA` is high.
- `TPB_PHASE`, 6: phase at which `TPB` is high and requests are sampled.

Ports:

- `CLOCK` in 1: single clock.
- `CLEAR_N` in 1: reset, asynchronous and active-low.
- `WAIT_N` in 1: synchronous pause, active-low.
- `INT_N` in 1: interrupt request, active-low level.
- `IE` in 1: interrupt enable from the core.
- `dma_in_req` in 1: DMA-in request, active-high level.
- `dma_out_req` in 1: DMA-out request, active-high level.
- `idle` in 1: core is executing IDL (0x00).
- `exec_more` in 1: core needs another S1 cycle, for example long branch or long skip.
- `SC` out 2: state code; S0=00, S1=01, S2=10, S3=11.
- `TPA` out 1: timing pulse A.
- `TPB` out 1: timing pulse B.
- `phase` out 3: current phase within the cycle.
- `commit` out 1: one-clock strobe at the last phase; the core latches state on it.
- `dma_in_gnt` out 1: high for the whole S2 cycle when it serves DMA-in.
- `dma_out_gnt` out 1: high for the whole S2 cycle when it serves DMA-out.
- `int_gnt` out 1: high for the whole S3 cycle.
- `init` out 1: high during the post-reset initialisation S1 cycle.

## Operation

- States: INIT (S1), FETCH (S0), EXEC (S1), DMA (S2), INTR (S3). `SC` is a registered decode of the state.
- Reset values: state INIT, `phase`=0, `SC`=01, `init`=1. All other outputs are 0.
- After `CLEAR_N` deasserts, INIT runs one full cycle, then the block enters FETCH.
- FETCH always goes to EXEC.
- Requests are latched at `TPB_PHASE` of EXEC, DMA and INTR cycles only. FETCH never samples them.
- Next-state decision is taken at the last phase. From EXEC:
  - `exec_more`=1 → EXEC. Requests latched in this cycle are discarded and re-sampled next cycle.
  - Otherwise priority is `dma_in_req` > `dma_out_req` > (`!INT_N` & `IE`) → DMA/DMA/INTR.
  - Otherwise EXEC if `idle`=1, else FETCH.
- From DMA: the same priority applies, so a held request gives back-to-back S2 bursts. With no request, go to EXEC if `idle`=1, else FETCH.
- From INTR: a DMA request → DMA; otherwise FETCH. Interrupts never chain directly, because `IE` is cleared by the core on S3.
- Simultaneous DMA-in and DMA-out: DMA-in is served first, then DMA-out on the next cycle if it is still requested.
- A DMA request and an interrupt together: DMA is served, and the interrupt is re-sampled in the following S2.

## Timing

- `phase` increments modulo `CYCLE_LEN`. Each state lasts exactly `CYCLE_LEN` clocks.
- `TPA`, `TPB` and `commit` are registered and last one clock each, at phases `TPA_PHASE`, `TPB_PHASE` and `CYCLE_LEN`-1.
- `SC` and the grants change on the clock edge entering phase 0. The decision uses request values latched at `TPB`, so it has zero extra latency.
- `WAIT_N`=0 freezes `phase`, the state and the latched requests. `TPA`, `TPB` and `commit` are forced to 0 while paused; `SC` and the grants hold their values.
- Pause resumes at the same phase. A pulse whose phase is the frozen one fires on the first clock after `WAIT_N` returns high.
- `CLEAR_N` asserted mid-cycle returns the block to reset values immediately; a partially elapsed cycle is discarded.

## Configuration

- `CDP1802_DMA_EN` defined: DMA arbitration as described above.
- `CDP1802_DMA_EN` undefined: `dma_in_req` and `dma_out_req` are ignored, `dma_in_gnt`/`dma_out_gnt` are tied to 0, and state DMA is unreachable.
- Interrupt handling is identical in both builds.

## Structure

- `cdp1802_pkg` holds:
  - the state-code constants `SC_FETCH`, `SC_EXEC`, `SC_DMA`, `SC_INT`;
  - the cycle-state enum;
  - the default `CYCLE_LEN`, `TPA_PHASE` and `TPB_PHASE`.
- Sub-module `cdp1802_phase_ctr` contains the phase counter with its pause gating, and generates `TPA`/`TPB`/`commit` from it.
- The arbiter FSM sits in the top level.

## Test plan

- Release `CLEAR_N`, all requests idle → cycle sequence INIT, S0, S1, S0, S1 with `init`=1 for exactly 8 clocks; `TPA` pulses at clock 1 and `TPB` at clock 6 of every cycle.
- Hold `dma_in_req` across three S1/S2 `TPB`s → after S1 the block runs S2, S2, S2 with `dma_in_gnt`=1, then S0 once the request drops.
- Raise `dma_in_req`, `dma_out_req` and `INT_N`=0 (`IE`=1) together before an S1 `TPB` → S2 (in), S2 (out), S3, S0.
- `idle`=1 with no requests → S1 repeats indefinitely. Then pull `INT_N`=0 with `IE`=1 → S3, then S0.
- Drive `WAIT_N`=0 for 5 clocks at phase 6 → `phase` holds at 6 and `TPB`=0 during the pause; `TPB` fires on the first clock after release and the cycle length becomes 13 clocks.
- Assert `exec_more` during S1 with `dma_in_req` high → S1, S1, then S2. Separately, assert `CLEAR_N`=0 at phase 4 → all outputs return to reset values immediately.
